// File: rtl/clk_div_prog_if.sv
// Control/status bundle for clk_div_prog: enable, phase clear, divide-value load
// path, and the divided clock / tick outputs.
interface clk_div_prog_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             sync_clr;
    logic [WIDTH-1:0] div_in;
    logic             div_ld;
    logic [WIDTH-1:0] div_cur;
    logic             div_pending;
    logic             clk_d;
    logic             tick;

    modport master (
        output en, sync_clr, div_in, div_ld,
        input  div_cur, div_pending, clk_d, tick
    );

    modport slave (
        input  en, sync_clr, div_in, div_ld,
        output div_cur, div_pending, clk_d, tick
    );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable 50%-duty clock divider with a tick strobe per half-period.
// New divide values are shadowed and only take effect when the count restarts.
module clk_div_prog #(
    parameter int WIDTH     = 8,
    parameter int DIV_RESET = 1
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    clk_div_prog_if.slave  bus
);
    localparam logic [WIDTH-1:0] LP_DIV_RST = DIV_RESET[WIDTH-1:0];

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_div_cur;
    logic             r_pending;
    logic             r_clk_d;
    logic             r_tick;

    logic             w_term;
    logic             w_apply;
    logic [WIDTH-1:0] w_new_div;

    assign w_term    = bus.en && (r_count == r_div_cur);
    // A same-cycle load beats the older shadow value.
    assign w_new_div = bus.div_ld ? bus.div_in : r_shadow;
    // Divide value only changes on edges that also reload the count with 0.
    assign w_apply   = (bus.sync_clr || w_term) && (bus.div_ld || r_pending);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count   <= '0;
            r_shadow  <= LP_DIV_RST;
            r_div_cur <= LP_DIV_RST;
            r_pending <= 1'b0;
            r_clk_d   <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            if (bus.div_ld)
                r_shadow <= bus.div_in;

            if (w_apply) begin
                r_div_cur <= w_new_div;
                r_pending <= 1'b0;
            end else if (bus.div_ld) begin
                r_pending <= 1'b1;
            end

            if (bus.sync_clr) begin
                r_count <= '0;
                r_clk_d <= 1'b0;
                r_tick  <= 1'b0;
            end else if (w_term) begin
                r_count <= '0;
                r_clk_d <= ~r_clk_d;
                r_tick  <= 1'b1;
            end else if (bus.en) begin
                r_count <= r_count + 1'b1;
                r_tick  <= 1'b0;
            end else begin
                r_tick  <= 1'b0;
            end
        end
    end

    assign bus.div_cur     = r_div_cur;
    assign bus.div_pending = r_pending;
    assign bus.clk_d       = r_clk_d;
    assign bus.tick        = r_tick;
endmodule

// File: tb/tb_clk_div_prog.sv
// Directed, table-driven bench for clk_div_prog (WIDTH=8, DIV_RESET=1).
module tb_clk_div_prog;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    clk_div_prog_if #(.WIDTH(8)) bus ();

    clk_div_prog #(.WIDTH(8), .DIV_RESET(1)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic       en;
        logic       clr;
        logic       ld;
        logic [7:0] din;
        logic       clk_d;
        logic       tick;
        logic [7:0] cur;
        logic       pend;
    } vec_t;

    vec_t vq[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0d want=%0d", name, idx, act, exp);
        end
    endtask

    task automatic addn(input int n, input logic en, input logic clr, input logic ld, input logic [7:0] din,
                        input logic clk_d, input logic tick, input logic [7:0] cur, input logic pend);
        vec_t v;
        v.en = en; v.clr = clr; v.ld = ld; v.din = din;
        v.clk_d = clk_d; v.tick = tick; v.cur = cur; v.pend = pend;
        for (int k = 0; k < n; k++) vq.push_back(v);
    endtask

    task automatic check_outs(input int idx, input logic clk_d, input logic tick, input logic [7:0] cur, input logic pend);
        chk("clk_d", idx, 32'(bus.clk_d), 32'(clk_d));
        chk("tick", idx, 32'(bus.tick), 32'(tick));
        chk("div_cur", idx, 32'(bus.div_cur), 32'(cur));
        chk("div_pending", idx, 32'(bus.div_pending), 32'(pend));
    endtask

    initial begin
        bus.en = 1'b0; bus.sync_clr = 1'b0; bus.div_ld = 1'b0; bus.div_in = '0;

        //   n  en clr ld din   clk_d tick cur pend
        // default ratio 1: period 4
        addn(1, 1, 0, 0, 0,   0, 0, 1, 0);
        addn(1, 1, 0, 0, 0,   1, 1, 1, 0);
        addn(1, 1, 0, 0, 0,   1, 0, 1, 0);
        addn(1, 1, 0, 0, 0,   0, 1, 1, 0);
        addn(1, 1, 0, 0, 0,   0, 0, 1, 0);
        addn(1, 1, 0, 0, 0,   1, 1, 1, 0);
        // load 3 one cycle after a transition
        addn(1, 1, 0, 1, 3,   1, 0, 1, 1);
        addn(1, 1, 0, 0, 0,   0, 1, 3, 0);
        addn(3, 1, 0, 0, 0,   0, 0, 3, 0);
        addn(1, 1, 0, 0, 0,   1, 1, 3, 0);
        addn(3, 1, 0, 0, 0,   1, 0, 3, 0);
        addn(1, 1, 0, 0, 0,   0, 1, 3, 0);
        // shadow=2 pending, then load 5 on the terminal edge
        addn(1, 1, 0, 1, 2,   0, 0, 3, 1);
        addn(2, 1, 0, 0, 0,   0, 0, 3, 1);
        addn(1, 1, 0, 1, 5,   1, 1, 5, 0);
        addn(5, 1, 0, 0, 0,   1, 0, 5, 0);
        addn(1, 1, 0, 0, 0,   0, 1, 5, 0);
        // back to 3, then pause enable with count at 2
        addn(1, 1, 0, 1, 3,   0, 0, 5, 1);
        addn(4, 1, 0, 0, 0,   0, 0, 5, 1);
        addn(1, 1, 0, 0, 0,   1, 1, 3, 0);
        addn(2, 1, 0, 0, 0,   1, 0, 3, 0);
        addn(7, 0, 0, 0, 0,   1, 0, 3, 0);
        addn(1, 1, 0, 0, 0,   1, 0, 3, 0);
        addn(1, 1, 0, 0, 0,   0, 1, 3, 0);
        // load 0 while disabled, divide-by-2, then sync_clr
        addn(1, 0, 0, 1, 0,   0, 0, 3, 1);
        addn(3, 1, 0, 0, 0,   0, 0, 3, 1);
        addn(1, 1, 0, 0, 0,   1, 1, 0, 0);
        addn(1, 1, 0, 0, 0,   0, 1, 0, 0);
        addn(1, 1, 0, 0, 0,   1, 1, 0, 0);
        addn(1, 1, 1, 0, 0,   0, 0, 0, 0);
        addn(1, 1, 0, 0, 0,   1, 1, 0, 0);
        // sync_clr applies pending shadow, and same-cycle div_in
        addn(1, 0, 0, 1, 4,   1, 0, 0, 1);
        addn(1, 0, 1, 0, 0,   0, 0, 4, 0);
        addn(1, 0, 1, 1, 2,   0, 0, 2, 0);
        addn(2, 1, 0, 0, 0,   0, 0, 2, 0);
        addn(1, 1, 0, 0, 0,   1, 1, 2, 0);
        // leave a value pending for the async reset check
        addn(1, 1, 0, 1, 7,   1, 0, 2, 1);

        repeat (2) @(negedge clk);
        check_outs(-1, 1'b0, 1'b0, 8'd1, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            bus.en = vq[i].en; bus.sync_clr = vq[i].clr;
            bus.div_ld = vq[i].ld; bus.div_in = vq[i].din;
            @(posedge clk);
            #1;
            check_outs(i, vq[i].clk_d, vq[i].tick, vq[i].cur, vq[i].pend);
        end

        // asynchronous reset mid-phase, no clock edge in between
        bus.div_ld = 1'b0; bus.div_in = '0;
        #2 rst_n = 1'b0;
        #1;
        check_outs(100, 1'b0, 1'b0, 8'd1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.en = 1'b1;
        @(posedge clk); #1;
        check_outs(101, 1'b0, 1'b0, 8'd1, 1'b0);
        @(posedge clk); #1;
        check_outs(102, 1'b1, 1'b1, 8'd1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
